// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared defaults and count-width helper for the negedge pipeline
package dff_pkg;

  localparam int          DEF_WIDTH     = 8;
  localparam int          DEF_DEPTH     = 4;
  // Wide enough for any legal WIDTH; users slice it down to their data width.
  localparam logic [63:0] DEF_RESET_VAL = 64'd0;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_neg_en.sv
// rtl/dff_neg_en.sv - single falling-edge register with load enable and async reset
module dff_neg_en #(
  parameter int           N    = 1,
  parameter logic [N-1:0] RVAL = '0
) (
  input  logic         CKN,
  input  logic         RST,
  input  logic         LD,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  // Reset wins immediately; otherwise capture D on a falling edge when loading.
  always_ff @(negedge CKN or posedge RST) begin
    if (RST) begin
      Q <= RVAL;
    end else if (LD) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/dff_neg_pipe.sv
// rtl/dff_neg_pipe.sv - falling-edge data/valid shift pipeline with flush and occupancy count
module dff_neg_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL[WIDTH-1:0]
) (
  input  logic                         CKN,
  input  logic                         RST,
  input  logic [WIDTH-1:0]             D,
  input  logic                         DV,
  input  logic                         EN,
  input  logic                         FLUSH,
  output logic [WIDTH-1:0]             Q,
  output logic                         QV,
  output logic [cnt_width(DEPTH)-1:0]  CNT
);

  localparam int CW = cnt_width(DEPTH);
  localparam int SW = WIDTH + 1;  // stage word: {data, valid}

  logic [DEPTH-1:0][SW-1:0] stage_q;
  logic                     stage_ld;
  logic [CW-1:0]            cnt_next;

  // A stage must load when shifting, and also on a held flush so its valid bit can drop.
  assign stage_ld = EN | FLUSH;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      logic [SW-1:0] shift_src;
      logic [SW-1:0] stage_nxt;

      if (g == 0) begin : g_head
        assign shift_src = {D, DV};
      end else begin : g_body
        assign shift_src = stage_q[g-1];
      end

      // Shift from upstream or recirculate own word; flush strips the valid bit either way.
      assign stage_nxt = EN ? {shift_src[SW-1:1], shift_src[0] & ~FLUSH}
                            : {stage_q[g][SW-1:1], stage_q[g][0] & ~FLUSH};

      dff_neg_en #(
        .N    (SW),
        .RVAL ({RESET_VAL, 1'b0})
      ) u_stage (
        .CKN (CKN),
        .RST (RST),
        .LD  (stage_ld),
        .D   (stage_nxt),
        .Q   (stage_q[g])
      );
    end
  endgenerate

  // Outputs come straight off the last stage register.
  assign Q  = stage_q[DEPTH-1][SW-1:1];
  assign QV = stage_q[DEPTH-1][0];

  // Subtract the leaving word before adding the entering one: QV=1 implies CNT>=1,
  // and CNT=DEPTH implies QV=1, so neither step can leave the 0..DEPTH range.
  assign cnt_next = (CNT - CW'(QV)) + CW'(DV);

  // Occupancy tracks valid tags: cleared by reset or flush, updated only on shift edges.
  always_ff @(negedge CKN or posedge RST) begin
    if (RST) begin
      CNT <= '0;
    end else if (FLUSH) begin
      CNT <= '0;
    end else if (EN) begin
      CNT <= cnt_next;
    end
  end

endmodule

// File: tb/tb_dff_neg_pipe.sv
// tb/tb_dff_neg_pipe.sv - scoreboard bench for dff_neg_pipe (DEPTH=4 and DEPTH=1 instances)
module tb_dff_neg_pipe;

  logic CKN = 1'b1;
  always #5 CKN = ~CKN;

  logic       rst = 1'b0;
  logic [7:0] d = 8'h00;
  logic       dv = 1'b0, en = 1'b0, flush = 1'b0;
  logic [7:0] q;
  logic       qv;
  logic [2:0] cnt;

  logic       rst1 = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic       dv1 = 1'b0, en1 = 1'b0, flush1 = 1'b0;
  logic [0:0] q1;
  logic       qv1;
  logic [0:0] cnt1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  dff_neg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hC3)) dut (
    .CKN(CKN), .RST(rst), .D(d), .DV(dv), .EN(en), .FLUSH(flush),
    .Q(q), .QV(qv), .CNT(cnt)
  );

  dff_neg_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
    .CKN(CKN), .RST(rst1), .D(d1), .DV(dv1), .EN(en1), .FLUSH(flush1),
    .Q(q1), .QV(qv1), .CNT(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one falling edge of stimulus, record expected output words, check CNT/QV after it.
  task automatic step(input string name, input logic e, input logic v, input logic [7:0] dd,
                      input logic f, input int ecnt, input logic eqv);
    #1;
    en = e; dv = v; d = dd; flush = f;
    if (f) sb.delete();
    else if (e && v && !rst) sb.push_back(dd);
    @(negedge CKN);
    #1;
    chk({name, "_cnt"}, 64'(cnt), 64'(ecnt));
    chk({name, "_qv"}, 64'(qv), 64'(eqv));
  endtask

  // Monitor: every shift edge that leaves a valid word on Q must match the scoreboard head.
  initial begin
    logic       shifted;
    logic [7:0] exp_w;
    forever begin
      @(negedge CKN);
      shifted = en && !flush && !rst;
      #1;
      if (shifted && qv) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got %0h expected none", q);
        end else begin
          exp_w = sb.pop_front();
          chk("sb_q", 64'(q), 64'(exp_w));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, applied between edges.
    #1 rst = 1'b1; rst1 = 1'b1;
    #1;
    chk("rst_q", 64'(q), 64'h C3);
    chk("rst_qv", 64'(qv), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst1_qv", 64'(qv1), 64'd0);
    #6 rst = 1'b0; rst1 = 1'b0;

    // Five words in, drain out.
    step("t1_w1", 1, 1, 8'h11, 0, 1, 0);
    step("t1_w2", 1, 1, 8'h22, 0, 2, 0);
    step("t1_w3", 1, 1, 8'h33, 0, 3, 0);
    step("t1_w4", 1, 1, 8'h44, 0, 4, 1);
    step("t1_w5", 1, 1, 8'h55, 0, 4, 1);
    step("t1_d1", 1, 0, 8'h00, 0, 3, 1);
    step("t1_d2", 1, 0, 8'h00, 0, 2, 1);
    step("t1_d3", 1, 0, 8'h00, 0, 1, 1);
    step("t1_d4", 1, 0, 8'h00, 0, 0, 0);

    // Two words, then hold three edges while D/DV toggle.
    step("t2_w1", 1, 1, 8'hA1, 0, 1, 0);
    step("t2_w2", 1, 1, 8'hA2, 0, 2, 0);
    step("t2_h1", 0, 1, 8'hFF, 0, 2, 0);
    chk("t2_h1_q", 64'(q), 64'h00);
    step("t2_h2", 0, 0, 8'h00, 0, 2, 0);
    chk("t2_h2_q", 64'(q), 64'h00);
    step("t2_h3", 0, 1, 8'h77, 0, 2, 0);
    chk("t2_h3_q", 64'(q), 64'h00);
    step("t2_r1", 1, 0, 8'h00, 0, 2, 0);
    step("t2_r2", 1, 0, 8'h00, 0, 2, 1);
    step("t2_r3", 1, 0, 8'h00, 0, 1, 1);
    step("t2_r4", 1, 0, 8'h00, 0, 0, 0);

    // Flush with EN=1 DV=1, then a fresh word; then flush while held.
    step("t3_w1", 1, 1, 8'hB1, 0, 1, 0);
    step("t3_w2", 1, 1, 8'hB2, 0, 2, 0);
    step("t3_w3", 1, 1, 8'hB3, 0, 3, 0);
    step("t3_fl", 1, 1, 8'hCC, 1, 0, 0);
    step("t3_a5", 1, 1, 8'hA5, 0, 1, 0);
    step("t3_d1", 1, 0, 8'h00, 0, 1, 0);
    step("t3_d2", 1, 0, 8'h00, 0, 1, 0);
    step("t3_d3", 1, 0, 8'h00, 0, 1, 1);
    step("t3_d4", 1, 0, 8'h00, 0, 0, 0);
    step("t3_c1", 1, 1, 8'hC1, 0, 1, 0);
    step("t3_c2", 1, 1, 8'hC2, 0, 2, 0);
    step("t3_flh", 0, 1, 8'hDD, 1, 0, 0);
    step("t3_x1", 1, 0, 8'hxx, 0, 0, 0);
    step("t3_x2", 1, 0, 8'hxx, 0, 0, 0);
    step("t3_x3", 1, 0, 8'hxx, 0, 0, 0);
    step("t3_x4", 1, 0, 8'hxx, 0, 0, 0);

    // Full pipe, DV=1 while full, then alternating DV.
    step("t4_f1", 1, 1, 8'hD1, 0, 1, 0);
    step("t4_f2", 1, 1, 8'hD2, 0, 2, 0);
    step("t4_f3", 1, 1, 8'hD3, 0, 3, 0);
    step("t4_f4", 1, 1, 8'hD4, 0, 4, 1);
    step("t4_f5", 1, 1, 8'hD5, 0, 4, 1);
    step("t4_a1", 1, 0, 8'h00, 0, 3, 1);
    step("t4_a2", 1, 1, 8'hE1, 0, 3, 1);
    step("t4_a3", 1, 0, 8'h00, 0, 2, 1);
    step("t4_a4", 1, 1, 8'hE2, 0, 2, 0);
    step("t4_a5", 1, 0, 8'h00, 0, 2, 1);
    step("t4_a6", 1, 1, 8'hE3, 0, 2, 0);

    // Refill to 4, reset mid-cycle, edges under reset, then recover.
    step("t5_f1", 1, 1, 8'hF1, 0, 3, 1);
    step("t5_f2", 1, 1, 8'hF2, 0, 3, 0);
    step("t5_f3", 1, 1, 8'hF3, 0, 4, 1);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("t5_rst_q", 64'(q), 64'hC3);
    chk("t5_rst_qv", 64'(qv), 64'd0);
    chk("t5_rst_cnt", 64'(cnt), 64'd0);
    step("t5_in_rst1", 1, 1, 8'h77, 0, 0, 0);
    chk("t5_in_rst1_q", 64'(q), 64'hC3);
    step("t5_in_rst2", 1, 1, 8'h78, 0, 0, 0);
    chk("t5_in_rst2_q", 64'(q), 64'hC3);
    #1 rst = 1'b0;
    step("t5_g1", 1, 1, 8'h61, 0, 1, 0);
    step("t5_g2", 1, 0, 8'h00, 0, 1, 0);
    step("t5_g3", 1, 0, 8'h00, 0, 1, 0);
    step("t5_g4", 1, 0, 8'h00, 0, 1, 1);
    step("t5_g5", 1, 0, 8'h00, 0, 0, 0);
    #1 en = 1'b0; dv = 1'b0;
    chk("sb_drain", 64'(sb.size()), 64'd0);

    // DEPTH=1, WIDTH=1: plain enabled negedge register.
    d1 = 1'b0; dv1 = 1'b1; en1 = 1'b1;
    @(negedge CKN); #1;
    chk("d1_w0_q", 64'(q1), 64'd0);
    chk("d1_w0_qv", 64'(qv1), 64'd1);
    chk("d1_w0_cnt", 64'(cnt1), 64'd1);
    d1 = 1'b1;
    @(negedge CKN); #1;
    chk("d1_w1_q", 64'(q1), 64'd1);
    chk("d1_w1_qv", 64'(qv1), 64'd1);
    chk("d1_w1_cnt", 64'(cnt1), 64'd1);
    d1 = 1'b0; dv1 = 1'b0;
    @(posedge CKN); #1;
    chk("d1_rise_q", 64'(q1), 64'd1);
    chk("d1_rise_qv", 64'(qv1), 64'd1);
    en1 = 1'b0;
    @(negedge CKN); #1;
    chk("d1_hold_q", 64'(q1), 64'd1);
    chk("d1_hold_cnt", 64'(cnt1), 64'd1);
    en1 = 1'b1;
    @(negedge CKN); #1;
    chk("d1_out_q", 64'(q1), 64'd0);
    chk("d1_out_qv", 64'(qv1), 64'd0);
    chk("d1_out_cnt", 64'(cnt1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
